// File: rtl/axis_frame_scheduler.sv
// Frame-level round-robin arbiter sharing one AXI-Stream FIFO slave port
// between N_SRC sources, with FIFO-space admission control and truncation
// of frames longer than MAX_BEATS.
module axis_frame_scheduler #(
  parameter  int N_SRC      = 4,
  parameter  int DATA_WIDTH = 16,
  parameter  int FIFO_DEPTH = 4096,
  parameter  int MAX_BEATS  = 512,
  parameter  int CNT_WIDTH  = 16,
  localparam int IDX_W      = $clog2(N_SRC),
  localparam int DEPTH_W    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [N_SRC-1:0]            s_axis_tvalid,
  output logic [N_SRC-1:0]            s_axis_tready,
  input  logic [N_SRC-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic [IDX_W-1:0]            m_axis_tid,
  output logic                        m_axis_tuser,
  input  logic [DEPTH_W-1:0]          fifo_status_depth,
  output logic                        grant_active,
  output logic [CNT_WIDTH-1:0]        frame_count,
  output logic [CNT_WIDTH-1:0]        trunc_count
);

  localparam int BC_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  // Largest occupancy that still leaves room for a maximum-size frame.
  localparam logic [DEPTH_W-1:0] ADMIT_MAX = DEPTH_W'(FIFO_DEPTH - MAX_BEATS);
  localparam logic [BC_W-1:0]    LAST_BEAT = BC_W'(MAX_BEATS - 1);
  localparam logic [IDX_W-1:0]   LAST_SRC  = IDX_W'(N_SRC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0]   frame_count_q, frame_count_d;
  logic [CNT_WIDTH-1:0]   trunc_count_q, trunc_count_d;

  logic [DATA_WIDTH-1:0]  src_data [N_SRC];
  logic [IDX_W-1:0]       cand;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic                   space_ok;
  logic                   src_valid;
  logic                   src_last;
  logic                   at_max;
  logic                   beat;

  // Unpack the flat source data bus into one word per source.
  always_comb begin
    for (int unsigned i = 0; i < N_SRC; i++) begin
      src_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Round-robin search: first valid source starting at rr_ptr, wrapping.
  always_comb begin
    cand       = '0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      cand = IDX_W'((32'(rr_ptr_q) + i) % N_SRC);
      if (!pick_valid && s_axis_tvalid[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign space_ok  = (fifo_status_depth <= ADMIT_MAX);
  assign src_valid = s_axis_tvalid[grant_q];
  assign src_last  = s_axis_tlast[grant_q];
  assign at_max    = (beat_cnt_q == LAST_BEAT);
  assign beat      = src_valid & m_axis_tready;

  assign frame_count = frame_count_q;
  assign trunc_count = trunc_count_q;

  // Next-state, counters and the combinational pass-through outputs.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    frame_count_d = frame_count_q;
    trunc_count_d = trunc_count_q;
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    m_axis_tid    = '0;
    grant_active  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (space_ok && pick_valid) begin
          grant_d = pick_idx;
          state_d = XFER;
        end
      end

      XFER: begin
        grant_active           = 1'b1;
        m_axis_tvalid          = src_valid;
        m_axis_tdata           = src_data[grant_q];
        m_axis_tid             = grant_q;
        s_axis_tready[grant_q] = m_axis_tready;
        m_axis_tlast           = src_last | at_max;
        m_axis_tuser           = at_max & ~src_last;
        if (beat) begin
          if (src_last || at_max) begin
            frame_count_d = frame_count_q + 1'b1;
            rr_ptr_d      = (grant_q == LAST_SRC) ? '0 : grant_q + 1'b1;
            beat_cnt_d    = '0;
            if (src_last) begin
              state_d = IDLE;
            end else begin
              trunc_count_d = trunc_count_q + 1'b1;
              state_d       = DRAIN;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end

      DRAIN: begin
        grant_active           = 1'b1;
        s_axis_tready[grant_q] = 1'b1;
        if (src_valid && src_last) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      beat_cnt_q    <= '0;
      frame_count_q <= '0;
      trunc_count_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      beat_cnt_q    <= beat_cnt_d;
      frame_count_q <= frame_count_d;
      trunc_count_q <= trunc_count_d;
    end
  end

endmodule

// File: tb/tb_axis_frame_scheduler.sv
// Randomized bench for axis_frame_scheduler against a frame-level model.
module tb_axis_frame_scheduler;

  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int FD  = 64;
  localparam int MB  = 8;
  localparam int CW  = 16;
  localparam int NF  = 8;
  localparam int IW  = 2;
  localparam int DPW = 7;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N-1:0]    s_axis_tvalid;
  logic [N-1:0]    s_axis_tready;
  logic [N-1:0]    s_axis_tlast;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic            m_axis_tlast;
  logic [IW-1:0]   m_axis_tid;
  logic            m_axis_tuser;
  logic [DPW-1:0]  fifo_status_depth;
  logic            grant_active;
  logic [CW-1:0]   frame_count;
  logic [CW-1:0]   trunc_count;

  axis_frame_scheduler #(
    .N_SRC      (N),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD),
    .MAX_BEATS  (MB),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .s_axis_tlast      (s_axis_tlast),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tid        (m_axis_tid),
    .m_axis_tuser      (m_axis_tuser),
    .fifo_status_depth (fifo_status_depth),
    .grant_active      (grant_active),
    .frame_count       (frame_count),
    .trunc_count       (trunc_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame lengths per source and frame index.
  int len_tab [N][NF];
  // Source driver progress.
  int dfi [N];
  int dbi [N];
  logic [N-1:0] acc;
  // Reference model: frame-level view of the scheduler.
  bit busy;
  bit drain;
  int cur_g;
  int cur_b;
  int mf [N];
  int rr;
  int exp_fc;
  int exp_tc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] beat_word(input int s, input int f, input int b);
    return {s[3:0], f[5:0], b[5:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ga"},    32'(grant_active),  32'd0);
    check({tag, "_sready"},32'(s_axis_tready), 32'd0);
    check({tag, "_mvalid"},32'(m_axis_tvalid), 32'd0);
    check({tag, "_tid"},   32'(m_axis_tid),    32'd0);
    check({tag, "_tlast"}, 32'(m_axis_tlast),  32'd0);
    check({tag, "_tuser"}, 32'(m_axis_tuser),  32'd0);
    check({tag, "_fc"},    32'(frame_count),   32'd0);
    check({tag, "_tc"},    32'(trunc_count),   32'd0);
  endtask

  // Advance sources past accepted beats and randomize the next cycle's inputs.
  task automatic drive();
    int r;
    for (int s = 0; s < N; s++) begin
      if (acc[s]) begin
        dbi[s]++;
        if (dbi[s] == len_tab[s][dfi[s]]) begin
          dfi[s]++;
          dbi[s] = 0;
        end
        s_axis_tvalid[s] = 1'b0;
        s_axis_tlast[s]  = 1'b0;
      end
      if (!s_axis_tvalid[s] && dfi[s] < NF && $urandom_range(0, 3) != 0) begin
        s_axis_tvalid[s]          = 1'b1;
        s_axis_tdata[s*DW +: DW]  = beat_word(s, dfi[s], dbi[s]);
        s_axis_tlast[s]           = (dbi[s] == len_tab[s][dfi[s]] - 1);
      end
    end
    m_axis_tready = ($urandom_range(0, 3) != 0);
    r = $urandom_range(0, 7);
    case (r)
      4:       fifo_status_depth = DPW'(20);
      5:       fifo_status_depth = DPW'(FD - MB);
      6:       fifo_status_depth = DPW'(FD - MB + 1);
      7:       fifo_status_depth = DPW'(FD);
      default: fifo_status_depth = '0;
    endcase
  endtask

  // Compare the DUT against the model at the sampling point, then step the model.
  task automatic monitor();
    logic [N-1:0] onehot;
    int L;
    int pick;
    check("frame_count", 32'(frame_count), 32'(exp_fc % (1 << CW)));
    check("trunc_count", 32'(trunc_count), 32'(exp_tc % (1 << CW)));
    if (!busy) begin
      check("idle_ga",     32'(grant_active),  32'd0);
      check("idle_sready", 32'(s_axis_tready), 32'd0);
      check("idle_mvalid", 32'(m_axis_tvalid), 32'd0);
      pick = -1;
      if (int'(fifo_status_depth) <= FD - MB) begin
        for (int k = 0; k < N; k++) begin
          int s;
          s = (rr + k) % N;
          if (pick < 0 && s_axis_tvalid[s]) pick = s;
        end
      end
      if (pick >= 0) begin
        busy  = 1'b1;
        drain = 1'b0;
        cur_g = pick;
        cur_b = 0;
      end
    end else if (!drain) begin
      onehot = 4'b0001 << cur_g;
      check("xfer_ga",     32'(grant_active),  32'd1);
      check("xfer_tid",    32'(m_axis_tid),    32'(cur_g));
      check("xfer_sready", 32'(s_axis_tready), m_axis_tready ? 32'(onehot) : 32'd0);
      check("xfer_mvalid", 32'(m_axis_tvalid), 32'(s_axis_tvalid[cur_g]));
      L = (mf[cur_g] < NF) ? len_tab[cur_g][mf[cur_g]] : 1;
      if (m_axis_tvalid) begin
        check("xfer_tdata", 32'(m_axis_tdata), 32'(beat_word(cur_g, mf[cur_g], cur_b)));
        check("xfer_tlast", 32'(m_axis_tlast), 32'((cur_b == MB - 1) || (cur_b == L - 1)));
        check("xfer_tuser", 32'(m_axis_tuser), 32'((cur_b == MB - 1) && (cur_b != L - 1)));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (cur_b == MB - 1 || cur_b == L - 1) begin
          exp_fc++;
          rr = (cur_g + 1) % N;
          mf[cur_g]++;
          if (cur_b != L - 1) begin
            exp_tc++;
            drain = 1'b1;
          end else begin
            busy = 1'b0;
          end
        end else begin
          cur_b++;
        end
      end
    end else begin
      onehot = 4'b0001 << cur_g;
      check("drain_ga",     32'(grant_active),  32'd1);
      check("drain_mvalid", 32'(m_axis_tvalid), 32'd0);
      check("drain_sready", 32'(s_axis_tready), 32'(onehot));
      if (s_axis_tvalid[cur_g] && s_axis_tlast[cur_g]) begin
        busy  = 1'b0;
        drain = 1'b0;
      end
    end
    acc = s_axis_tvalid & s_axis_tready;
  endtask

  initial begin
    bit done;
    rst_n             = 1'b0;
    s_axis_tdata      = '0;
    s_axis_tvalid     = '0;
    s_axis_tlast      = '0;
    m_axis_tready     = 1'b0;
    fifo_status_depth = '0;
    acc               = '0;
    for (int s = 0; s < N; s++) begin
      dfi[s] = 0;
      dbi[s] = 0;
      mf[s]  = 0;
      for (int f = 0; f < NF; f++) len_tab[s][f] = $urandom_range(1, 12);
    end
    len_tab[0][0] = 4;
    len_tab[1][0] = 12;
    len_tab[2][0] = MB;
    len_tab[3][0] = 1;
    len_tab[1][1] = MB + 1;
    busy   = 1'b0;
    drain  = 1'b0;
    cur_g  = 0;
    cur_b  = 0;
    rr     = 0;
    exp_fc = 0;
    exp_tc = 0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Randomized traffic until every source has sent all its frames.
    done = 1'b0;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      drive();
      @(negedge clk);
      monitor();
      done = !busy && (s_axis_tvalid == '0);
      for (int s = 0; s < N; s++) if (dfi[s] < NF) done = 1'b0;
      @(posedge clk);
      #1;
    end
    check("random_done", 32'(done), 32'd1);
    check("final_fc", 32'(frame_count), 32'(exp_fc));
    check("final_tc", 32'(trunc_count), 32'(exp_tc));

    // Directed: leave rr_ptr at 3, then reset in the middle of a frame.
    s_axis_tvalid     = 4'b0100;
    s_axis_tlast      = 4'b0100;
    s_axis_tdata      = '0;
    s_axis_tdata[2*DW +: DW] = 16'h2AAA;
    m_axis_tready     = 1'b1;
    fifo_status_depth = '0;
    tick();
    check("dir_grant2", 32'(m_axis_tid), 32'd2);
    tick();
    s_axis_tvalid = 4'b0001;
    s_axis_tlast  = 4'b0000;
    s_axis_tdata[0 +: DW] = 16'h0B01;
    tick();
    check("dir_grant0_ga",  32'(grant_active), 32'd1);
    check("dir_grant0_tid", 32'(m_axis_tid),   32'd0);
    tick();
    tick();
    check("dir_beat3_valid", 32'(m_axis_tvalid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    s_axis_tvalid = 4'b1010;
    s_axis_tlast  = 4'b1010;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("post_reset_ga",  32'(grant_active), 32'd1);
    check("post_reset_tid", 32'(m_axis_tid),   32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
